// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the pixel/colour stage.
//   DrawX, DrawY       : current raster position (10 bit)
//   blank              : 1 while the position is inside the visible area
//   hs, vs             : sync pulses aligned with DrawX/DrawY
//   hs_d, vs_d, blank_d: the same signals delayed for alignment at the encoder
//   frame_start        : one-clock pulse at (0,0)
//   line_start         : one-clock pulse at DrawX = 0
//   frame_cnt          : number of completed frames (16 bit, wraps)
interface vga_timing_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        hs_d;
    logic        vs_d;
    logic        blank_d;
    logic        frame_start;
    logic        line_start;
    logic [15:0] frame_cnt;

    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, line_start, frame_cnt
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
               frame_start, line_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
//   vga_clk : pixel clock, all logic on its rising edge
//   reset_n : synchronous active-low reset
//   vga     : vga_timing_if.master carrying position, blank, syncs, delayed
//             syncs/blank, frame/line strobes and the frame counter
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RESET | held in reset; counters at (0,0), outputs inactive
// ST_RUN   | raster running; counters advance every clock
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 1
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_geometry
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);
    localparam logic       SYNC_OFF   = ~SYNC_ON;

    typedef enum logic {ST_RESET, ST_RUN} state_t;

    state_t      state, state_nxt;
    logic [9:0]  x, y, x_nxt, y_nxt;
    logic [15:0] fcnt, fcnt_nxt;
    logic        blank_r, hs_r, vs_r, fs_r, ls_r;
    logic        blank_nxt, hs_nxt, vs_nxt, fs_nxt, ls_nxt;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state   <= ST_RESET;
            x       <= '0;
            y       <= '0;
            fcnt    <= '0;
            blank_r <= 1'b0;
            hs_r    <= SYNC_OFF;
            vs_r    <= SYNC_OFF;
            fs_r    <= 1'b0;
            ls_r    <= 1'b0;
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            fcnt    <= fcnt_nxt;
            blank_r <= blank_nxt;
            hs_r    <= hs_nxt;
            vs_r    <= vs_nxt;
            fs_r    <= fs_nxt;
            ls_r    <= ls_nxt;
        end
    end

    // Outputs are decoded from the next counter values so that, once
    // registered, they line up with DrawX/DrawY in the same cycle.
    always_comb begin
        state_nxt = ST_RUN;
        x_nxt     = x;
        y_nxt     = y;
        fcnt_nxt  = fcnt;

        // Leaving reset holds the counters at (0,0) for the first RUN cycle.
        if (state == ST_RUN) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                if (y == V_LAST) begin
                    y_nxt    = '0;
                    fcnt_nxt = fcnt + 16'd1;
                end else begin
                    y_nxt = y + 10'd1;
                end
            end else begin
                x_nxt = x + 10'd1;
            end
        end

        blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt    = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_nxt    = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_ON : SYNC_OFF;
        ls_nxt    = (x_nxt == 10'd0);
        fs_nxt    = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end

    assign vga.DrawX       = x;
    assign vga.DrawY       = y;
    assign vga.blank       = blank_r;
    assign vga.hs          = hs_r;
    assign vga.vs          = vs_r;
    assign vga.frame_start = fs_r;
    assign vga.line_start  = ls_r;
    assign vga.frame_cnt   = fcnt;

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign vga.hs_d    = hs_r;
            assign vga.vs_d    = vs_r;
            assign vga.blank_d = blank_r;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe, vs_pipe, blank_pipe;

            // Reset flushes every stage so no stale pre-reset sync escapes.
            always_ff @(posedge vga_clk) begin
                if (!reset_n) begin
                    hs_pipe    <= {PIPE_DELAY{SYNC_OFF}};
                    vs_pipe    <= {PIPE_DELAY{SYNC_OFF}};
                    blank_pipe <= '0;
                end else begin
                    hs_pipe[0]    <= hs_r;
                    vs_pipe[0]    <= vs_r;
                    blank_pipe[0] <= blank_r;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_pipe[i]    <= hs_pipe[i-1];
                        vs_pipe[i]    <= vs_pipe[i-1];
                        blank_pipe[i] <= blank_pipe[i-1];
                    end
                end
            end

            assign vga.hs_d    = hs_pipe[PIPE_DELAY-1];
            assign vga.vs_d    = vs_pipe[PIPE_DELAY-1];
            assign vga.blank_d = blank_pipe[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_if if_a ();
    vga_timing_if if_b ();
    vga_timing_if if_c ();

    // a: small raster, active-low sync, one-clock delay
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(0), .PIPE_DELAY(1)
    ) dut_a (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_a.master));

    // b: different raster, active-high sync, three-clock delay
    vga_timing_gen #(
        .H_VISIBLE(12), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(3), .V_BP(2),
        .SYNC_POL(1), .PIPE_DELAY(3)
    ) dut_b (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_b.master));

    // c: 1x1 raster, one frame per clock, exercises the frame_cnt wrap
    vga_timing_gen #(
        .H_VISIBLE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_VISIBLE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
        .SYNC_POL(0), .PIPE_DELAY(0)
    ) dut_c (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_c.master));

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc  = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: position is a pure function of the number of clocks
    // spent running since reset release. History slot k describes the
    // situation k clocks ago; a reset clears the whole history.
    bit     in_rst = 1'b1;
    longint t_run  = 0;
    bit     h_rst [5];
    longint h_t   [5];

    typedef struct {
        longint x, y, fcnt;
        bit blank, hs, vs, fs, ls;
    } exp_t;

    function automatic exp_t model(input int hv, hfp, hsy, hbp, vv, vfp, vsy, vbp,
                                   input bit pol, input bit rst, input longint t);
        exp_t e;
        longint ht, vt;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        if (rst) begin
            e.x = 0; e.y = 0; e.fcnt = 0;
            e.blank = 0; e.hs = ~pol; e.vs = ~pol; e.fs = 0; e.ls = 0;
        end else begin
            e.x     = t % ht;
            e.y     = (t / ht) % vt;
            e.fcnt  = (t / (ht * vt)) % 65536;
            e.blank = (e.x < hv) && (e.y < vv);
            e.hs    = (e.x >= hv + hfp && e.x < hv + hfp + hsy) ? pol : ~pol;
            e.vs    = (e.y >= vv + vfp && e.y < vv + vfp + vsy) ? pol : ~pol;
            e.ls    = (e.x == 0);
            e.fs    = (e.x == 0) && (e.y == 0);
        end
        return e;
    endfunction

    task automatic check_dut(input string tag,
                             input int hv, hfp, hsy, hbp, vv, vfp, vsy, vbp,
                             input bit pol, input int dly,
                             input logic [9:0] ox, oy, input logic oblank, ohs, ovs,
                             input logic ohs_d, ovs_d, oblank_d, ofs, ols,
                             input logic [15:0] ofcnt);
        exp_t e, ed;
        e  = model(hv, hfp, hsy, hbp, vv, vfp, vsy, vbp, pol, h_rst[0], h_t[0]);
        ed = model(hv, hfp, hsy, hbp, vv, vfp, vsy, vbp, pol, h_rst[dly], h_t[dly]);
        check_val({tag, ".DrawX"},       longint'(ox),       e.x);
        check_val({tag, ".DrawY"},       longint'(oy),       e.y);
        check_val({tag, ".blank"},       longint'(oblank),   longint'(e.blank));
        check_val({tag, ".hs"},          longint'(ohs),      longint'(e.hs));
        check_val({tag, ".vs"},          longint'(ovs),      longint'(e.vs));
        check_val({tag, ".line_start"},  longint'(ols),      longint'(e.ls));
        check_val({tag, ".frame_start"}, longint'(ofs),      longint'(e.fs));
        check_val({tag, ".frame_cnt"},   longint'(ofcnt),    e.fcnt);
        check_val({tag, ".hs_d"},        longint'(ohs_d),    longint'(ed.hs));
        check_val({tag, ".vs_d"},        longint'(ovs_d),    longint'(ed.vs));
        check_val({tag, ".blank_d"},     longint'(oblank_d), longint'(ed.blank));
    endtask

    longint last_fs_a = -1;

    task automatic check_all();
        check_dut("a", 16, 4, 6, 4, 10, 2, 2, 3, 1'b0, 1,
                  if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hs, if_a.vs,
                  if_a.hs_d, if_a.vs_d, if_a.blank_d, if_a.frame_start,
                  if_a.line_start, if_a.frame_cnt);
        check_dut("b", 12, 2, 3, 5, 6, 1, 3, 2, 1'b1, 3,
                  if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hs, if_b.vs,
                  if_b.hs_d, if_b.vs_d, if_b.blank_d, if_b.frame_start,
                  if_b.line_start, if_b.frame_cnt);
        check_dut("c", 1, 0, 0, 0, 1, 0, 0, 0, 1'b0, 0,
                  if_c.DrawX, if_c.DrawY, if_c.blank, if_c.hs, if_c.vs,
                  if_c.hs_d, if_c.vs_d, if_c.blank_d, if_c.frame_start,
                  if_c.line_start, if_c.frame_cnt);
        // frame_start spacing on a: 30 x 17 clocks per frame
        if (if_a.frame_start === 1'b1) begin
            if (last_fs_a >= 0)
                check_val("a.frame_period", cyc - last_fs_a, 64'd510);
            last_fs_a = cyc;
        end
    endtask

    task automatic step(input bit rn);
        reset_n = rn;
        @(posedge vga_clk);
        cyc++;
        if (!rn) begin
            in_rst    = 1'b1;
            last_fs_a = -1;
            for (int k = 0; k < 5; k++) begin
                h_rst[k] = 1'b1;
                h_t[k]   = 0;
            end
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                t_run  = 0;
            end else begin
                t_run++;
            end
            for (int k = 4; k > 0; k--) begin
                h_rst[k] = h_rst[k-1];
                h_t[k]   = h_t[k-1];
            end
            h_rst[0] = 1'b0;
            h_t[0]   = t_run;
        end
        @(negedge vga_clk);
        check_all();
    endtask

    initial begin
        int guard;
        for (int k = 0; k < 5; k++) begin
            h_rst[k] = 1'b1;
            h_t[k]   = 0;
        end

        // reset held for 5 clocks, then a long run that carries c's
        // frame counter through 65536 frames and back to zero
        for (int i = 0; i < 5; i++) step(1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b1);
            if (t_run == 65536)
                check_val("c.frame_cnt_wrap", longint'(if_c.frame_cnt), 64'd0);
        end

        // one-clock reset in the middle of a's frame at (8,5)
        guard = 0;
        while (!(t_run % 510 == 158) && guard < 1000) begin
            step(1'b1);
            guard++;
        end
        check_val("a.midframe_reached", longint'(guard < 1000), 64'd1);
        step(1'b0);
        check_val("a.midframe_hs_d",    longint'(if_a.hs_d),    64'd1);
        check_val("a.midframe_blank_d", longint'(if_a.blank_d), 64'd0);
        step(1'b1);
        check_val("a.restart_frame_start", longint'(if_a.frame_start), 64'd1);

        // randomized run/reset interleaving
        for (int r = 0; r < 15; r++) begin
            int run_len, rst_len;
            run_len = $urandom_range(1, 600);
            rst_len = $urandom_range(1, 5);
            for (int i = 0; i < run_len; i++) step(1'b1);
            for (int i = 0; i < rst_len; i++) step(1'b0);
        end
        for (int i = 0; i < 1100; i++) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
